mux_sel_arb: RTL and testbench



---
 rtl/mux_sel_pkg.sv | 17 +
 rtl/mux_sel_arb_grant_timer.sv | 37 +++
 rtl/mux_sel_arb.sv | 117 +++++++++++
 tb/tb_mux_sel_arb.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types and defaults for the 2:1 mux select arbiter.
// Used by mux_sel_arb and its grant_timer.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int HOLD_DEF = 4;
  localparam int MAX_DEF  = 16;

endpackage

// File: rtl/mux_sel_arb_grant_timer.sv
// Grant-age counter: clears on grant entry, counts while owned,
// saturates at all-ones; flags hold satisfied and max-age reached.
module grant_timer
  import mux_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int MAX_GRANT   = MAX_DEF,
  parameter int CNT_W       = $clog2(MAX_GRANT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hold_done,
  output logic max_hit
);

  localparam logic [CNT_W-1:0] AGE_SAT  = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_GRANT - 1);

  logic [CNT_W-1:0] age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (clr) begin
      age <= '0;
    end else if (en && age != AGE_SAT) begin
      age <= age + 1'b1;
    end
  end

  assign hold_done = (age >= HOLD_LIM);
  assign max_hit   = (age == MAX_LIM);

endmodule

// File: rtl/mux_sel_arb.sv
// Two-requester arbiter driving a registered, glitch-free mux select.
// Define MUX_SEL_ARB_TIMEOUT_EN to force a switch after MAX_GRANT cycles.
module mux_sel_arb
  import mux_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int MAX_GRANT   = MAX_DEF,
  parameter int CNT_W       = $clog2(MAX_GRANT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic switch_p,
  output logic timeout_p
);

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t state, state_nxt;
  logic   sel_nxt;
  logic   last_owner;
  logic   entry;
  logic   force_sw;
  logic   own_req;
  logic   oth_req;
  logic   hold_done;
  logic   max_hit;
  state_t tie_win;
  state_t other_gnt;

  assign own_req   = (state == GNT_B) ? req_b : req_a;
  assign oth_req   = (state == GNT_B) ? req_a : req_b;
  assign other_gnt = (state == GNT_A) ? GNT_B : GNT_A;
  assign tie_win   = (last_owner == SEL_B) ? GNT_A : GNT_B;

  always_comb begin
    state_nxt = state;
    force_sw  = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          req_a && req_b:   state_nxt = tie_win;
          req_a && !req_b:  state_nxt = GNT_A;
          !req_a && req_b:  state_nxt = GNT_B;
          !req_a && !req_b: state_nxt = IDLE;
        endcase
      end
      GNT_A, GNT_B: begin
        if (hold_done) begin
          unique case (1'b1)
            TO_EN && own_req && oth_req && max_hit: begin
              state_nxt = other_gnt;
              force_sw  = 1'b1;
            end
            own_req && !(TO_EN && oth_req && max_hit):
              state_nxt = state;
            !own_req && oth_req:
              state_nxt = other_gnt;
            !own_req && !oth_req:
              state_nxt = IDLE;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_nxt = sel;
    if (state_nxt == GNT_A) sel_nxt = SEL_A;
    if (state_nxt == GNT_B) sel_nxt = SEL_B;
  end

  assign entry = (state_nxt != IDLE) && (state_nxt != state);

  grant_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .MAX_GRANT   (MAX_GRANT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (entry),
    .en        (state != IDLE),
    .hold_done (hold_done),
    .max_hit   (max_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= SEL_A;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      switch_p   <= 1'b0;
      timeout_p  <= 1'b0;
      last_owner <= SEL_B;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      gnt_a      <= (state_nxt == GNT_A);
      gnt_b      <= (state_nxt == GNT_B);
      switch_p   <= (sel_nxt != sel);
      timeout_p  <= force_sw;
      if (entry) last_owner <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_arb.sv
// Bench for mux_sel_arb: reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_mux_sel_arb;

  localparam int HOLD = 4;
  localparam int MAXG = 16;
  localparam int SAT  = 31;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic sel, gnt_a, gnt_b, switch_p, timeout_p;

  int n_chk = 0;
  int n_fail = 0;

  mux_sel_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .sel       (sel),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .switch_p  (switch_p),
    .timeout_p (timeout_p)
  );

  always #5 clk = ~clk;

  // model: owner 0=none 1=A 2=B
  int m_own = 0;
  int m_age = 0;
  int m_last = 2;
  int m_sel = 0;
  int m_sw = 0;
  int m_to = 0;

  always @(posedge clk or negedge rst_n) begin
    int nxt, mine, other, prev, t;
    if (!rst_n) begin
      m_own = 0; m_age = 0; m_last = 2;
      m_sel = 0; m_sw = 0; m_to = 0;
    end else begin
      prev = m_sel;
      nxt = m_own;
      t = 0;
      if (m_own == 0) begin
        if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
        else if (req_a) nxt = 1;
        else if (req_b) nxt = 2;
      end else begin
        mine = (m_own == 1) ? int'(req_a) : int'(req_b);
        other = (m_own == 1) ? int'(req_b) : int'(req_a);
        if (m_age >= HOLD - 1) begin
          if (TO && mine != 0 && other != 0 && m_age == MAXG - 1) begin
            nxt = 3 - m_own;
            t = 1;
          end else if (mine == 0) begin
            nxt = (other != 0) ? 3 - m_own : 0;
          end
        end
      end
      if (nxt != 0 && nxt != m_own) begin
        m_age = 0;
        m_last = nxt;
      end else if (m_own != 0 && m_age < SAT) begin
        m_age = m_age + 1;
      end
      if (nxt != 0) m_sel = nxt - 1;
      m_sw = (m_sel != prev) ? 1 : 0;
      m_to = t;
      m_own = nxt;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_sel", int'(sel), m_sel);
    check("model_gnt_a", int'(gnt_a), int'(m_own == 1));
    check("model_gnt_b", int'(gnt_b), int'(m_own == 2));
    check("model_switch", int'(switch_p), m_sw);
    check("model_timeout", int'(timeout_p), m_to);
  end

  task automatic drive(input logic a, input logic b, input int n);
    req_a = a;
    req_b = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin(input string name, input logic s, input logic ga,
                     input logic gb, input logic sw);
    check({name, "_sel"}, int'(sel), int'(s));
    check({name, "_gnt_a"}, int'(gnt_a), int'(ga));
    check({name, "_gnt_b"}, int'(gnt_b), int'(gb));
    check({name, "_sw"}, int'(switch_p), int'(sw));
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    pin("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_to", int'(timeout_p), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 10);
    pin("idle10", 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1, 0, 1);
    pin("single_on", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 3);
    pin("single_hold", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1);
    pin("single_off", 1'b0, 1'b0, 1'b0, 1'b0);

    do_reset();
    drive(1, 1, 1);
    pin("tie_a", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1, 1, 3);
    pin("tie_a_hold", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(0, 1, 1);
    pin("tie_to_b", 1'b1, 1'b0, 1'b1, 1'b1);
    drive(0, 1, 1);
    pin("b_pulse_end", 1'b1, 1'b0, 1'b1, 1'b0);

    drive(1, 0, 2);
    pin("hold_prot", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1, 0, 1);
    pin("hold_rel_a", 1'b0, 1'b1, 1'b0, 1'b1);

    drive(0, 0, 4);
    pin("a_to_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1, 1);
    pin("rr_b", 1'b1, 1'b0, 1'b1, 1'b1);

    drive(1, 1, 15);
    pin("long_b", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1, 1, 1);
    if (TO) pin("timeout_sw", 1'b0, 1'b1, 1'b0, 1'b1);
    else    pin("no_timeout", 1'b1, 1'b0, 1'b1, 1'b0);
    check("timeout_p", int'(timeout_p), int'(TO));
    drive(1, 1, 20);

    do_reset();
    drive(0, 0, 3);
    pin("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
